seq_signed_multiplier: RTL and testbench
========================================

# seq_signed_multiplier

Parametrised sequential shift-and-add signed multiplier with a start/done handshake, generalising the team's 8-bit datapath to WIDTH bits. Operands are converted to magnitudes, multiplied by an internal FSM, and the sign is applied before the result is presented. The block sits between the operand registers and the binary-to-BCD display path, and holds its product stable for downstream consumers until the next accepted start.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mc  in  WIDTH  signed two's-complement multiplicand (shift-right operand)
- mp  in  WIDTH  signed two's-complement multiplier (shift-left operand)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; product valid
- product  out  2*WIDTH  signed two's-complement result, held until next accepted start
- neg  out  1  registered sign of result (mc[W-1]^mp[W-1], forced 0 if result is zero)

## Operation
- States: IDLE, RUN, SIGN, DONE.
- IDLE: on start=1, register sr <= |mc| (WIDTH bits, unsigned), sl <= zero-extended |mp| (2*WIDTH bits), acc <= 0, cnt <= 0, sign <= mc[W-1]^mp[W-1]; go to RUN. Operands are not sampled at any other time.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits as unsigned WIDTH bits; no saturation is required.
- RUN, per cycle: if sr[0], acc <= acc + sl (2*WIDTH-bit add, no carry-out possible); sl <= sl<<1; sr <= sr>>1; cnt <= cnt+1. Exit to SIGN after the cycle in which cnt reaches WIDTH-1 (exactly WIDTH RUN cycles).
- SIGN: product <= sign ? -acc : acc; neg <= sign & (acc != 0); go to DONE.
- DONE: done=1 for this single cycle; go to IDLE unconditionally.
- start is ignored while busy=1 (RUN, SIGN, DONE); it is not queued.
- Zero operand: product = 0, neg = 0, regardless of operand signs.
- product and neg change only on the SIGN→DONE edge.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, product=0, neg=0; internal acc, sl, sr, cnt cleared. Applied mid-operation, the operation is aborted and no done is issued.
- Let edge E0 be the edge sampling start in IDLE. busy rises after E0. RUN occupies WIDTH cycles, SIGN one cycle, and DONE one cycle. done is high in cycle WIDTH+2 after E0 (10 for WIDTH=8).
- busy falls together with done on the DONE→IDLE edge. A new start is accepted in the first IDLE cycle, giving a minimum issue interval of WIDTH+3 cycles.
- start held high continuously: a new operation begins on each IDLE cycle.

## Configuration
- MULT_EARLY_TERM_EN defined: RUN also exits to SIGN after any cycle in which the shifted sr becomes 0.
  - Latency = (position of highest set bit of |mc|)+1 RUN cycles, minimum 1; done follows k+2 cycles after E0 for k RUN cycles.
  - mc=0 gives 1 RUN cycle. Results are identical to the non-terminated mode.
- Not defined: fixed WIDTH RUN cycles; latency is data-independent.

## Test plan
- WIDTH=8, mc=5, mp=3, start pulse -> done exactly 10 cycles after start edge, product=16'h000F, neg=0; busy high for 10 cycles.
- mc=-128, mp=-128 -> product=16'h4000 (16384), neg=0; mc=-7, mp=9 -> product=16'hFFC1 (-63), neg=1.
- mc=0, mp=-5 -> product=0, neg=0. With MULT_EARLY_TERM_EN: done 3 cycles after start; mc=1 -> also 3 cycles; mc=-128 -> 10 cycles.
- Second start with new operands pulsed during RUN -> ignored; first result unchanged and held after done; no second done without a new start in IDLE.
- rst asserted at RUN cycle 4 -> busy, done, product, neg go to 0 immediately; after release, a new start 6*7 produces product=42 with normal latency.
- WIDTH=16 regression: random signed operand pairs plus corner values ±1, 0, -32768, 32767 -> product matches the signed reference model, and done latency is 18 cycles, or highest-bit+3 cycles with early termination.

Source files
------------

// File: rtl/seq_signed_multiplier_if.sv
// Operand/result bundle for seq_signed_multiplier; master drives start and operands,
// slave returns busy/done and the held signed product.
interface seq_signed_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                      start;
  logic signed [WIDTH-1:0]   mc;
  logic signed [WIDTH-1:0]   mp;
  logic                      busy;
  logic                      done;
  logic signed [2*WIDTH-1:0] product;
  logic                      neg;

  modport master (
    output start, mc, mp,
    input  busy, done, product, neg
  );

  modport slave (
    input  start, mc, mp,
    output busy, done, product, neg
  );
endinterface

// File: rtl/seq_signed_multiplier.sv
// Sequential shift-and-add signed multiplier: done WIDTH+2 cycles after start (fewer with MULT_EARLY_TERM_EN).
// start is only sampled in IDLE and never queued; product/neg hold until the next operation completes.
module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  seq_signed_multiplier_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sr;
  logic [PW-1:0]    sl;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             sign;

  logic [WIDTH-1:0] mc_mag;
  logic [WIDTH-1:0] mp_mag;
  logic             run_last;

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  always_comb begin
    mc_mag = bus.mc[WIDTH-1] ? (-bus.mc) : bus.mc;
    mp_mag = bus.mp[WIDTH-1] ? (-bus.mp) : bus.mp;
  end

  always_comb begin
    run_last = (cnt == CW'(WIDTH - 1));
`ifdef MULT_EARLY_TERM_EN
    if (sr[WIDTH-1:1] == '0) begin
      run_last = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sr          <= '0;
      sl          <= '0;
      acc         <= '0;
      cnt         <= '0;
      sign        <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
      bus.neg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            sr       <= mc_mag;
            sl       <= {{WIDTH{1'b0}}, mp_mag};
            acc      <= '0;
            cnt      <= '0;
            sign     <= bus.mc[WIDTH-1] ^ bus.mp[WIDTH-1];
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          // Magnitudes are below 2^(WIDTH-1)+1 each, so the sum never overflows PW bits.
          if (sr[0]) begin
            acc <= acc + sl;
          end
          sl  <= sl << 1;
          sr  <= sr >> 1;
          cnt <= cnt + CW'(1);
          if (run_last) begin
            state <= SIGN;
          end
        end

        SIGN: begin
          bus.product <= sign ? (-acc) : acc;
          bus.neg     <= sign & (acc != '0);
          bus.done    <= 1'b1;
          state       <= DONE;
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Directed + random bench for seq_signed_multiplier at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_seq_signed_multiplier;
  logic clk;
  logic rst;

  seq_signed_multiplier_if #(.WIDTH(8))  if8  ();
  seq_signed_multiplier_if #(.WIDTH(16)) if16 ();

  seq_signed_multiplier #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  seq_signed_multiplier #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic        neg;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] prod_of(input int w);
    if (w == 8) return {16'h0, if8.product};
    return if16.product;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 8) ? if8.done : if16.done;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 8) ? if8.busy : if16.busy;
  endfunction

  function automatic logic neg_of(input int w);
    return (w == 8) ? if8.neg : if16.neg;
  endfunction

  function automatic int exp_lat(input int w, input int a);
`ifdef MULT_EARLY_TERM_EN
    int mag;
    int hb;
    mag = (a < 0) ? -a : a;
    hb  = 0;
    for (int i = 0; i < w; i++) begin
      if (mag[i]) hb = i;
    end
    return hb + 3;
`else
    return w + 2;
`endif
  endfunction

  task automatic drive(input int w, input logic s, input int a, input int b);
    if (w == 8) begin
      if8.start = s;
      if8.mc    = a[7:0];
      if8.mp    = b[7:0];
    end else begin
      if16.start = s;
      if16.mc    = a[15:0];
      if16.mp    = b[15:0];
    end
  endtask

  task automatic push_exp(input int w, input int a, input int b);
    exp_t        e;
    longint      p;
    logic [31:0] t;
    p = longint'(a) * longint'(b);
    t = 32'(p);
    e.prod = (w == 8) ? {16'h0, t[15:0]} : t;
    e.neg  = (p < 0);
    e.lat  = exp_lat(w, a);
    sb.push_back(e);
  endtask

  task automatic check_done(input int w, input int n);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(n), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check("latency", 32'(n), 32'(e.lat));
      check("product", prod_of(w), e.prod);
      check("neg", {31'h0, neg_of(w)}, {31'h0, e.neg});
    end
  endtask

  // Issue one op; optionally pulse a different start while busy at cycle pulse_at.
  task automatic run_op(input int w, input int a, input int b, input int pulse_at);
    int          n;
    int          gaps;
    int          extra;
    logic [31:0] held;
    push_exp(w, a, b);
    @(negedge clk);
    drive(w, 1'b1, a, b);
    n    = -1;
    gaps = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) drive(w, 1'b0, a, b);
      if (pulse_at > 0 && i == pulse_at) drive(w, 1'b1, a + 3, -b - 1);
      if (pulse_at > 0 && i == pulse_at + 1) drive(w, 1'b0, a, b);
      if (done_of(w)) begin
        n = i;
        break;
      end
      if (!busy_of(w)) gaps++;
    end
    check("busy_during_op", 32'(gaps), 32'd0);
    check("busy_at_done", {31'h0, busy_of(w)}, 32'd1);
    check_done(w, n);
    held = prod_of(w);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done_of(w)}, 32'd0);
    check("busy_after_done", {31'h0, busy_of(w)}, 32'd0);
    if (pulse_at > 0) begin
      extra = 0;
      repeat (15) begin
        @(negedge clk);
        if (done_of(w)) extra++;
      end
      check("no_second_done", 32'(extra), 32'd0);
      check("product_held", prod_of(w), held);
    end
  endtask

  initial begin
    int n1;
    int n2;
    int extra;
    int a;
    int b;

    rst = 1'b0;
    drive(8, 1'b0, 0, 0);
    drive(16, 1'b0, 0, 0);
    #1;
    check("rst_busy8", {31'h0, if8.busy}, 32'd0);
    check("rst_done8", {31'h0, if8.done}, 32'd0);
    check("rst_product8", prod_of(8), 32'd0);
    check("rst_neg8", {31'h0, if8.neg}, 32'd0);
    check("rst_busy16", {31'h0, if16.busy}, 32'd0);
    check("rst_product16", prod_of(16), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // WIDTH=8 directed values
    run_op(8, 5, 3, 0);
    run_op(8, -128, -128, 0);
    run_op(8, -7, 9, 0);
    run_op(8, 0, -5, 0);
    run_op(8, 1, -1, 0);
    run_op(8, 127, -128, 0);
    run_op(8, -5, 0, 0);

    // Start pulsed while busy is ignored and the first result is held.
    run_op(8, 5, 3, 2);

    // Reset in the fourth RUN cycle aborts the op.
    @(negedge clk);
    drive(8, 1'b1, 100, 3);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) drive(8, 1'b0, 100, 3);
    end
    rst = 1'b0;
    #1;
    check("abort_busy", {31'h0, if8.busy}, 32'd0);
    check("abort_done", {31'h0, if8.done}, 32'd0);
    check("abort_product", prod_of(8), 32'd0);
    check("abort_neg", {31'h0, if8.neg}, 32'd0);
    @(negedge clk);
    rst   = 1'b1;
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (if8.done) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
    run_op(8, 6, 7, 0);

    // start held high: the next op is accepted in the first IDLE cycle.
    push_exp(8, 3, 4);
    @(negedge clk);
    drive(8, 1'b1, 3, 4);
    n1 = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (if8.done) begin
        n1 = i;
        break;
      end
    end
    check_done(8, n1);
    push_exp(8, -2, 5);
    drive(8, 1'b1, -2, 5);
    n2 = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 2) drive(8, 1'b0, -2, 5);
      if (if8.done) begin
        n2 = i - 1;
        break;
      end
    end
    check_done(8, n2);

    // WIDTH=16 corners then random pairs
    run_op(16, 1, -1, 0);
    run_op(16, -1, -1, 0);
    run_op(16, 0, -32768, 0);
    run_op(16, -32768, -32768, 0);
    run_op(16, 32767, 32767, 0);
    run_op(16, -32768, 32767, 0);
    run_op(16, 32767, -1, 0);
    run_op(16, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      b = int'($urandom_range(0, 65535)) - 32768;
      run_op(16, a, b, 0);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
